// File: rtl/alu_share_arb_pkg.sv
// Shared ALU definitions for alu_share_arb: op-select width and op-code constants.
package alu_share_arb_pkg;
  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] ALU_ADD = 3'd0;
  localparam logic [SEL_W-1:0] ALU_SUB = 3'd1;
  localparam logic [SEL_W-1:0] ALU_XOR = 3'd2;
  localparam logic [SEL_W-1:0] ALU_OR  = 3'd3;
  localparam logic [SEL_W-1:0] ALU_AND = 3'd4;
  localparam logic [SEL_W-1:0] ALU_SLL = 3'd5;
  localparam logic [SEL_W-1:0] ALU_SRL = 3'd6;
  localparam logic [SEL_W-1:0] ALU_SRA = 3'd7;
endpackage

// File: rtl/alu_share_arb_if.sv
// Request/result bundle between the requesting stages (master) and alu_share_arb (slave).
interface alu_share_arb_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) ();
  import alu_share_arb_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ*WIDTH-1:0] req_in2;
  logic [NREQ*SEL_W-1:0] req_sel;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic                  res_flag;
  logic [IDW-1:0]        res_id;

  modport slave (
    input  req_valid, req_in1, req_in2, req_sel, res_ready,
    output req_ready, res_valid, res_data, res_flag, res_id
  );

  modport master (
    output req_valid, req_in1, req_in2, req_sel, res_ready,
    input  req_ready, res_valid, res_data, res_flag, res_id
  );
endinterface

// File: rtl/alu_share_arb_rr_arbiter.sv
// One-hot grant plus encoded index; round-robin from ptr+1, or lowest-index-first
// when ALU_SHARE_ARB_FIXED_PRIO_EN is defined (ptr port disappears in that build).
module alu_share_arb_rr_arbiter
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]  ptr,
`endif
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (en && !any && req[i]) begin
        grant[i] = 1'b1;
        idx      = IDW'(i);
        any      = 1'b1;
      end
    end
  end
`else
  int j;

  // ptr is always < NREQ, so a single wrap subtraction suffices
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (en && !any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDW'(j);
        any      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NREQ requesters with a one-entry result register.
// Define ALU_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no rr pointer).
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          rst,
  alu_share_arb_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_flag_q;
  logic [IDW-1:0]   res_id_q;

  logic             can_accept;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gidx;
  logic             gany;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SEL_W-1:0] op_sel;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_out;
  logic             alu_flag;

  // rst gating keeps any handshake from completing while reset is held
  assign can_accept = (!res_valid_q || bus.res_ready) && !rst;

`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= IDW'(NREQ - 1);
    else if (gany) ptr <= gidx;
  end
`endif

  alu_share_arb_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .en    (can_accept),
`ifndef ALU_SHARE_ARB_FIXED_PRIO_EN
    .ptr   (ptr),
`endif
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign bus.req_ready = grant;

  // gidx is 0 when nothing is granted, so the ALU then sees requester 0
  always_comb begin
    op_a   = bus.req_in1[int'(gidx)*WIDTH +: WIDTH];
    op_b   = bus.req_in2[int'(gidx)*WIDTH +: WIDTH];
    op_sel = bus.req_sel[int'(gidx)*SEL_W +: SEL_W];
    shamt  = op_b[SHW-1:0];
  end

  // Shared ALU: out1 = result, out2 = zero flag
  always_comb begin
    alu_out = '0;
    case (op_sel)
      ALU_ADD: alu_out = op_a + op_b;
      ALU_SUB: alu_out = op_a - op_b;
      ALU_XOR: alu_out = op_a ^ op_b;
      ALU_OR:  alu_out = op_a | op_b;
      ALU_AND: alu_out = op_a & op_b;
      ALU_SLL: alu_out = op_a << shamt;
      ALU_SRL: alu_out = op_a >> shamt;
      ALU_SRA: alu_out = $signed(op_a) >>> shamt;
      default: alu_out = '0;
    endcase
    alu_flag = (alu_out == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flag_q  <= 1'b0;
      res_id_q    <= '0;
    end else if (gany) begin
      res_valid_q <= 1'b1;
      res_data_q  <= alu_out;
      res_flag_q  <= alu_flag;
      res_id_q    <= gidx;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flag  = res_flag_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized + directed bench for alu_share_arb against a behavioural arbiter/ALU model.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  alu_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // stimulus state
  logic [NREQ-1:0]  rv;
  logic [WIDTH-1:0] in1 [NREQ];
  logic [WIDTH-1:0] in2 [NREQ];
  logic [2:0]       sel [NREQ];
  int               last_g = -1;

  // reference state
  bit               m_vld;
  logic [WIDTH-1:0] m_data;
  bit               m_flag;
  int               m_id;
  int               m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
    int sh;
    sh = int'(b % WIDTH);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a ^ b;
      3'd3: return a | b;
      3'd4: return a & b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return $signed(a) >>> sh;
    endcase
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v);
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_in1[i*WIDTH +: WIDTH] = in1[i];
      bus.req_in2[i*WIDTH +: WIDTH] = in2[i];
      bus.req_sel[i*3 +: 3]         = sel[i];
    end
    bus.req_valid = rv;
  endtask

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_flag = 0; m_id = 0; m_ptr = NREQ - 1;
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance model, move to next edge.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_rdy;
    drive();
    @(negedge clk);
    g = (!m_vld || bus.res_ready) ? pick(rv) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("res_valid", bus.res_valid, m_vld);
    if (m_vld) begin
      chk("res_data", bus.res_data, m_data);
      chk("res_flag", bus.res_flag, m_flag);
      chk("res_id", bus.res_id, m_id);
    end
    last_g = g;
    if (g >= 0) begin
      m_data = alu_ref(in1[g], in2[g], sel[g]);
      m_flag = (m_data == '0);
      m_id   = g;
      m_vld  = 1;
      m_ptr  = g;
    end else if (bus.res_ready) begin
      m_vld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_id;
    rst = 1'b1;
    rv = '0;
    for (int i = 0; i < NREQ; i++) begin in1[i] = '0; in2[i] = '0; sel[i] = '0; end
    bus.res_ready = 1'b1;
    drive();
    model_reset();
    #12;
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_data", bus.res_data, 0);
    chk("rst_flag", bus.res_flag, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_ready", bus.req_ready, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // single add
    rv = 2'b01; in1[0] = 5; in2[0] = 3; sel[0] = ALU_ADD;
    cycle();
    rv = '0;
    chk("add_valid", bus.res_valid, 1);
    chk("add_data", bus.res_data, 8);
    chk("add_id", bus.res_id, 0);
    cycle();

    // subtract wrap from requester 1
    rv = 2'b10; in1[1] = 0; in2[1] = 1; sel[1] = ALU_SUB;
    cycle();
    rv = '0;
    chk("sub_data", bus.res_data, 32'hFFFF_FFFF);
    chk("sub_id", bus.res_id, 1);
    cycle();

    // both valid continuously
    rv = 2'b11; in1[0] = 10; in2[0] = 6; sel[0] = ALU_XOR; in1[1] = 7; in2[1] = 9; sel[1] = ALU_OR;
    for (int n = 0; n < 4; n++) begin
      cycle();
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = n % 2;
`endif
      chk("rr_id", bus.res_id, exp_id);
    end
    rv = '0;
    cycle();

    // backpressure holds an arithmetic-shift result
    rv = 2'b01; in1[0] = 32'h8000_0000; in2[0] = 4; sel[0] = ALU_SRA;
    cycle();
    rv = 2'b10; in1[1] = 1; in2[1] = 2; sel[1] = ALU_ADD;
    bus.res_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("bp_data", bus.res_data, 32'hF800_0000);
    end
    bus.res_ready = 1'b1;
    cycle();
    chk("bp_swap_valid", bus.res_valid, 1);
    chk("bp_swap_id", bus.res_id, 1);
    chk("bp_swap_data", bus.res_data, 3);

    // requester 0 pulses valid while output is stalled
    rv = 2'b01; in1[0] = 100; in2[0] = 1; sel[0] = ALU_ADD;
    bus.res_ready = 1'b0;
    cycle();
    rv = '0;
    cycle();
    chk("drop_id", bus.res_id, 1);
    bus.res_ready = 1'b1;
    cycle();

    // reset while a result is pending
    rv = 2'b01; in1[0] = 1; in2[0] = 1; sel[0] = ALU_AND;
    cycle();
    rv = '0;
    bus.res_ready = 1'b0;
    drive();
    #1 rst = 1'b1;
    #1 chk("rst_mid_valid", bus.res_valid, 0);
    rv = 2'b11; drive();
    #1 chk("rst_mid_ready", bus.req_ready, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) begin rst = 1'b0; rv = '0; drive(); end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    rv = 2'b11; in1[0] = 4; in2[0] = 1; sel[0] = ALU_SLL; in1[1] = 4; in2[1] = 1; sel[1] = ALU_SRL;
    cycle();
    chk("post_rst_id", bus.res_id, 0);
    chk("post_rst_data", bus.res_data, 8);
    rv = '0;
    cycle();

    // random traffic honouring the hold-until-ready rule
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rv[i] && i != last_g) begin
          if ($urandom_range(7) == 0) rv[i] = 1'b0;
        end else begin
          rv[i]  = ($urandom_range(9) < 6);
          in1[i] = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
          in2[i] = ($urandom_range(3) == 0) ? in1[i] : $urandom;
          sel[i] = 3'($urandom_range(7));
        end
      end
      bus.res_ready = ($urandom_range(9) < 7);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational ALU instance between NREQ requesters (e.g. IFU PC adder, EXU, LSU address generation).
- Round-robin arbitration over valid/ready request channels.
- Captures the selected operation's ALU result in a one-entry output register with its own valid/ready handshake.
- Sits between the requesting pipeline stages and the single ALU datapath.

Parameters:
- WIDTH, 32, operand/result bit width passed to the ALU
- NREQ, 2, number of requesters, must be >= 2
- IDW, $clog2(NREQ), width of the requester id field

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept, at most one bit set
- req_in1  input  NREQ*WIDTH  operand 1, requester i at bits [i*WIDTH +: WIDTH]
- req_in2  input  NREQ*WIDTH  operand 2, same packing
- req_sel  input  NREQ*3  op select, requester i at [i*3 +: 3]; 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra
- res_valid  output  1  result register holds a result
- res_ready  input  1  consumer accepts the result
- res_data  output  WIDTH  registered ALU out1
- res_flag  output  1  registered ALU out2, passed through unchanged
- res_id  output  IDW  index of the requester that produced the result

Behaviour:
- Reset values, applied asynchronously:
  - res_valid=0, res_data=0, res_flag=0, res_id=0
  - rr pointer (last granted) = NREQ-1, so requester 0 has highest priority after reset
- can_accept = !res_valid || res_ready, combinational.
- Grant:
  - When can_accept, the first i with req_valid[i] set is granted, searching from ptr+1 and wrapping modulo NREQ.
  - req_ready[i] = grant[i], combinational from req_valid, ptr and can_accept.
  - req_ready is all-zero when !can_accept or no request is valid.
- Requester rule: hold req_valid, in1, in2 and sel stable until req_ready is seen. A requester may drop req_valid without penalty; no pointer change occurs.
- ALU inputs are muxed from the granted requester. When nothing is granted, the inputs are driven from requester 0 and the result is ignored.
- Accept cycle (any grant bit set):
  - Next edge loads res_data/res_flag from the ALU, loads res_id = granted index, sets res_valid=1.
  - ptr <= granted index.
- Latency: accept in cycle N, res_valid in cycle N+1. Throughput is 1 op/cycle while res_ready=1.
- Drain without a new grant: res_valid=1 && res_ready=1 && no grant, so res_valid<=0 next edge.
- Simultaneous drain and accept: new result replaces the old in the same edge and res_valid stays 1 (no bubble).
- Backpressure: res_valid=1 && res_ready=0 holds res_data/res_flag/res_id stable and forces req_ready=0.
- Arithmetic: all add/sub wrap modulo 2^WIDTH. Shift-amount interpretation belongs to the ALU; this block never modifies operands.
- Reset mid-operation: a pending result is dropped, the pointer returns to NREQ-1, and no handshake completes in the reset cycle.

Optional Feature:
- Macro: ALU_SHARE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The ptr register is removed and starvation of high indices is allowed.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package/header alu_defs holds the ALU op-code constants (ALU_ADD=3'd0 … ALU_SRA=3'd7) and the sel width (3).
- One sub-module is natural: rr_arbiter (NREQ param; inputs req vector, enable, ptr; output one-hot grant plus encoded index). The fixed-priority variant lives inside it under the macro.
- The ALU is instantiated once inside alu_share_arb.

Test Plan:
- Single add: after reset, req_valid=2'b01, in1=5, in2=3, sel=0, res_ready=1 -> req_ready=2'b01 same cycle; next cycle res_valid=1, res_data=8, res_id=0.
- Sub wrap: requester 1, in1=0, in2=1, sel=1 -> res_data=32'hFFFF_FFFF, res_id=1.
- Round-robin: both valid continuously, res_ready=1 -> grants 0,1,0,1 on consecutive cycles, res_id follows one cycle later. With FIXED_PRIO_EN: always 0.
- Backpressure: result 32'h8000_0000>>>4 (sel=7, in2=4) held with res_ready=0 for 3 cycles -> res_data=32'hF800_0000 stable, req_ready=0. Then res_ready=1 with req1 valid -> drain and accept in the same cycle, res_valid stays 1.
- Reset mid-op: assert rst while res_valid=1 -> res_valid=0 immediately (asynchronous). After release, both valid -> requester 0 granted first.
- Drop request: req_valid[0] pulsed 1 cycle while res_ready=0 -> no grant, no result, ptr unchanged.
